// File: rtl/i2c_ov7670_cfg_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_ov7670_cfg_seq
//
// Purpose: Walks the OV7670 configuration LUT after power-up. It fetches each
// {register, data} word, hands it to the SCCB byte-write engine, waits for
// completion, and then idles for an inter-write gap. The gap is longer after a
// soft-reset write (reg 0x12 with data bit 7 set). It counts entries that are
// NACKed and raises cfg_done once every entry has been written.
//
// Optional feature macro: I2C_CFG_RETRY_EN
//   defined   - a NACKed entry is retried up to MAX_RETRY times. Each retry is
//               preceded by a GAP_DLY gap. The entry counts as failed only if
//               the final attempt also NACKs.
//   undefined - no retry logic. A NACK fails the entry immediately.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cfg_start         - restart pulse, honoured only when configuration is done
//   LUT_INDEX         - index driven to the combinational config LUT
//   LUT_DATA          - {reg[15:8], data[7:0]} returned by the LUT
//   i2c_req           - one-cycle write request to the SCCB engine
//   i2c_dev           - sensor write address (constant DEV_ADDR)
//   i2c_reg, i2c_wdat - register/data, stable from i2c_req until i2c_done
//   i2c_busy          - engine busy
//   i2c_done          - one-cycle write-complete pulse
//   i2c_nack          - NACK flag, qualified by i2c_done
//   cfg_busy          - sequence in progress
//   cfg_done          - all entries written (level)
//   err               - sticky: at least one entry failed
//   err_cnt           - number of failed entries, saturating at 255
// ---------------------------------------------------------------------------
module i2c_ov7670_cfg_seq #(
  parameter int         LUT_SIZE  = 168,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         PWRUP_DLY = 1_000_000,
  parameter int         GAP_DLY   = 500,
  parameter int         RST_DLY   = 50_000,
  parameter int         MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  output logic [7:0]  LUT_INDEX,
  input  logic [15:0] LUT_DATA,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdat,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Terminal counts: a delay of N cycles ends when the counter reaches N-1.
  localparam logic [19:0] PWRUP_END = 20'(PWRUP_DLY - 1);
  localparam logic [19:0] GAP_END   = 20'(GAP_DLY - 1);
  localparam logic [19:0] RST_END   = 20'(RST_DLY - 1);
  localparam logic [7:0]  LAST_IDX  = 8'(LUT_SIZE - 1);

  state_t      state, state_next;
  logic [19:0] cnt;
  logic [19:0] gap_end;
  logic        soft_rst;

  // Strobes from the next-state logic to the register process
  logic        load;
  logic        req_set;
  logic        idx_inc;
  logic        fail;
  logic        restart;

`ifdef I2C_CFG_RETRY_EN
  logic [7:0]  retry_cnt;
  logic        retry_pend;  // the GAP in progress precedes a retry, not a new entry
  logic        retry_inc;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  assign i2c_dev  = DEV_ADDR;
  assign cfg_done = (state == DONE);
  assign cfg_busy = (state != DONE);

  // i2c_reg/i2c_wdat still hold the entry just written while in GAP.
  assign soft_rst = (i2c_reg == 8'h12) && i2c_wdat[7];

`ifdef I2C_CFG_RETRY_EN
  assign gap_end = (!retry_pend && soft_rst) ? RST_END : GAP_END;
`else
  assign gap_end = soft_rst ? RST_END : GAP_END;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    req_set    = 1'b0;
    idx_inc    = 1'b0;
    fail       = 1'b0;
    restart    = 1'b0;
`ifdef I2C_CFG_RETRY_EN
    retry_inc  = 1'b0;
`endif
    case (state)
      PWRUP: begin
        if (cnt == PWRUP_END) state_next = FETCH;
      end
      FETCH: begin
        load       = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (!i2c_busy) begin
          req_set    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i2c_done) begin
          state_next = GAP;
          if (i2c_nack) begin
`ifdef I2C_CFG_RETRY_EN
            if (retry_cnt < 8'(MAX_RETRY)) retry_inc = 1'b1;
            else                           fail      = 1'b1;
`else
            fail = 1'b1;
`endif
          end
        end
      end
      GAP: begin
        if (cnt == gap_end) begin
`ifdef I2C_CFG_RETRY_EN
          if (retry_pend) begin
            state_next = ISSUE;
          end else
`endif
          if (LUT_INDEX == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_inc    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        if (cfg_start) begin
          restart    = 1'b1;
          state_next = PWRUP;
        end
      end
      default: state_next = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      cnt       <= '0;
      LUT_INDEX <= '0;
      i2c_req   <= 1'b0;
      i2c_reg   <= '0;
      i2c_wdat  <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
`ifdef I2C_CFG_RETRY_EN
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      // Counter restarts from zero on every state entry, including GAP->ISSUE.
      cnt     <= (state_next != state) ? '0 : cnt + 20'd1;
      // Registered request: it rises one cycle after FETCH loads reg/data.
      i2c_req <= req_set;
      if (load) begin
        i2c_reg  <= LUT_DATA[15:8];
        i2c_wdat <= LUT_DATA[7:0];
      end
      if (idx_inc) LUT_INDEX <= LUT_INDEX + 8'd1;
      if (fail) begin
        err     <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
      end
      if (restart) begin
        LUT_INDEX <= '0;
        err       <= 1'b0;
        err_cnt   <= '0;
      end
`ifdef I2C_CFG_RETRY_EN
      if (load)           retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 8'd1;
      if (state == WAIT && i2c_done) retry_pend <= retry_inc;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_ov7670_cfg_seq.sv
`timescale 1ns/1ps
// Directed bench for i2c_ov7670_cfg_seq with small delays, a 3-entry LUT model
// and a SCCB engine model. Cycle numbers count rising edges after reset release
// (first edge with rst low is cycle 1).
module tb_i2c_ov7670_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [7:0]  LUT_INDEX;
  logic [15:0] LUT_DATA;
  logic        i2c_req;
  logic [7:0]  i2c_dev;
  logic [7:0]  i2c_reg;
  logic [7:0]  i2c_wdat;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_nack;
  logic        cfg_busy;
  logic        cfg_done;
  logic        err;
  logic [7:0]  err_cnt;

  i2c_ov7670_cfg_seq #(
    .LUT_SIZE (3),
    .DEV_ADDR (8'h42),
    .PWRUP_DLY(16),
    .GAP_DLY  (4),
    .RST_DLY  (10),
    .MAX_RETRY(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .LUT_INDEX(LUT_INDEX),
    .LUT_DATA (LUT_DATA),
    .i2c_req  (i2c_req),
    .i2c_dev  (i2c_dev),
    .i2c_reg  (i2c_reg),
    .i2c_wdat (i2c_wdat),
    .i2c_busy (i2c_busy),
    .i2c_done (i2c_done),
    .i2c_nack (i2c_nack),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // LUT model
  logic [15:0] lut [4];
  assign LUT_DATA = (LUT_INDEX < 8'd3) ? lut[LUT_INDEX[1:0]] : 16'h0000;

  // Engine model state and request log
  logic        eng_busy;
  logic        eng_nack;
  logic        hold_busy;
  int          eng_cnt;
  int          nack_idx;
  assign i2c_busy = eng_busy | hold_busy;

  int          cyc;
  int          nreq;
  int          lcyc [16];
  logic [7:0]  lreg [16];
  logic [7:0]  ldat [16];
  logic [7:0]  ldev [16];
  int          done_cyc;
  int          req_in_busy;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter, engine model (5 busy cycles, then a done pulse) and monitor.
  // The engine is deliberately not reset by rst: an abandoned write still
  // completes and its done pulse must be ignored.
  initial begin
    logic bsy_s;
    cyc = 0; nreq = 0; eng_cnt = 0; eng_busy = 1'b0; eng_nack = 1'b0;
    i2c_done = 1'b0; i2c_nack = 1'b0; done_cyc = -1; req_in_busy = 0;
    forever begin
      @(posedge clk);
      bsy_s = i2c_busy;
      if (rst) cyc = 0; else cyc = cyc + 1;
      #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (i2c_req) begin
        if (bsy_s) req_in_busy++;
        if (nreq < 16) begin
          lcyc[nreq] = cyc;
          lreg[nreq] = i2c_reg;
          ldat[nreq] = i2c_wdat;
          ldev[nreq] = i2c_dev;
        end
        nreq++;
      end
      if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_busy = 1'b0;
          i2c_done = 1'b1;
          i2c_nack = eng_nack;
        end
      end else if (i2c_req) begin
        eng_busy = 1'b1;
        eng_cnt  = 5;
        eng_nack = (int'(LUT_INDEX) == nack_idx);
      end
      if (cfg_done && done_cyc < 0) done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nreq = 0;
    done_cyc = -1;
    req_in_busy = 0;
  endtask

  task automatic wait_cyc(input int k);
    for (int i = 0; i < 2000 && cyc < k; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!cfg_done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cfg_done, 1'b1);
  endtask

  task automatic chk_req(input string tag, input int i, input int c,
                         input logic [7:0] r, input logic [7:0] d);
    chk({tag, "_cyc"}, lcyc[i], c);
    chk({tag, "_reg"}, lreg[i], r);
    chk({tag, "_dat"}, ldat[i], d);
    chk({tag, "_dev"}, ldev[i], 8'h42);
  endtask

  initial begin
    int c;
    rst = 1'b1; cfg_start = 1'b0; hold_busy = 1'b0; nack_idx = -1;
    lut[0] = 16'h3a04; lut[1] = 16'h40d0; lut[2] = 16'h1181; lut[3] = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_idx",     LUT_INDEX, 8'd0);
    chk("rst_req",     i2c_req,   1'b0);
    chk("rst_reg",     i2c_reg,   8'h00);
    chk("rst_wdat",    i2c_wdat,  8'h00);
    chk("rst_busy",    cfg_busy,  1'b1);
    chk("rst_done",    cfg_done,  1'b0);
    chk("rst_err",     err,       1'b0);
    chk("rst_err_cnt", err_cnt,   8'd0);

    // Nominal run with a cfg_start pulse mid-run (must be ignored)
    rst = 1'b0; nreq = 0; done_cyc = -1;
    wait_cyc(10);
    chk("pwrup_idx", LUT_INDEX, 8'd0);
    wait_cyc(17);
    chk("fetch_reg",  i2c_reg,  8'h3a);
    chk("fetch_wdat", i2c_wdat, 8'h04);
    chk("fetch_req",  i2c_req,  1'b0);
    wait_cyc(25);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("nom_done");
    chk("nom_nreq", nreq, 3);
    chk_req("nom_e0", 0, 18, 8'h3a, 8'h04);
    chk_req("nom_e1", 1, 30, 8'h40, 8'hd0);
    chk_req("nom_e2", 2, 42, 8'h11, 8'h81);
    chk("nom_done_cyc", done_cyc, 52);
    chk("nom_err",   err,      1'b0);
    chk("nom_busy",  cfg_busy, 1'b0);
    chk("nom_final_idx", LUT_INDEX, 8'd2);

    // Soft-reset entry: the gap after entry 1 is 10 cycles
    lut[1] = 16'h1280;
    do_reset();
    wait_done("srst_done");
    chk("srst_nreq", nreq, 3);
    chk_req("srst_e1", 1, 30, 8'h12, 8'h80);
    chk("srst_e2_cyc", lcyc[2], 48);
    chk("srst_done_cyc", done_cyc, 58);
    lut[1] = 16'h40d0;

    // Engine busy held for 20 cycles before entry 2
    do_reset();
    wait_cyc(38);
    hold_busy = 1'b1;
    repeat (20) @(negedge clk);
    hold_busy = 1'b0;
    chk("bsy_nreq_held", nreq, 2);
    wait_done("bsy_done");
    chk("bsy_e2_cyc", lcyc[2], 59);
    chk("bsy_req_in_busy", req_in_busy, 0);
    chk("bsy_done_cyc", done_cyc, 69);

    // rst pulsed while waiting on entry 1
    do_reset();
    wait_cyc(32);
    chk("mid_pre_idx", LUT_INDEX, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_idx",     LUT_INDEX, 8'd0);
    chk("mid_req",     i2c_req,   1'b0);
    chk("mid_reg",     i2c_reg,   8'h00);
    chk("mid_wdat",    i2c_wdat,  8'h00);
    chk("mid_busy",    cfg_busy,  1'b1);
    chk("mid_done",    cfg_done,  1'b0);
    chk("mid_err",     err,       1'b0);
    chk("mid_err_cnt", err_cnt,   8'd0);
    rst = 1'b0; nreq = 0; done_cyc = -1;
    wait_done("mid_rerun_done");
    chk("mid_nreq", nreq, 3);
    chk_req("mid_e0", 0, 18, 8'h3a, 8'h04);
    chk("mid_done_cyc", done_cyc, 52);

    // NACK on entry 0, every attempt
    nack_idx = 0;
    do_reset();
    wait_done("nack_done");
    chk("nack_err",     err,     1'b1);
    chk("nack_err_cnt", err_cnt, 8'd1);
`ifdef I2C_CFG_RETRY_EN
    chk("nack_nreq", nreq, 6);
    chk("nack_retry3_cyc", lcyc[3], 51);
    chk_req("nack_e1", 4, 63, 8'h40, 8'hd0);
    chk("nack_done_cyc", done_cyc, 85);
`else
    chk("nack_nreq", nreq, 3);
    chk_req("nack_e1", 1, 30, 8'h40, 8'hd0);
    chk("nack_done_cyc", done_cyc, 52);
`endif

    // cfg_start in DONE: full rerun with err/err_cnt cleared
    nack_idx = -1;
    nreq = 0;
    done_cyc = -1;
    c = cyc;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("rs_done",    cfg_done, 1'b0);
    chk("rs_busy",    cfg_busy, 1'b1);
    chk("rs_err",     err,      1'b0);
    chk("rs_err_cnt", err_cnt,  8'd0);
    chk("rs_idx",     LUT_INDEX, 8'd0);
    wait_done("rs_rerun_done");
    chk("rs_nreq", nreq, 3);
    chk_req("rs_e0", 0, c + 19, 8'h3a, 8'h04);
    chk("rs_done_cyc", done_cyc, c + 53);
    chk("rs_final_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
